// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   aorig_q, aorig_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_ext, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step, prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        op_signed = ~op_i[0];
        abs_a     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        abs_b     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

        // Multiply: accumulator is {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        // Divide: accumulator is {partial remainder, dividend bits / quotient bits}.
        rem_ext  = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rem_ext - {1'b0, opnd_q};
        div_next = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        step = is_div_q ? div_next : mul_next;
        prod = neg_q  ? -step : step;
        quo  = neg_q  ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem  = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        aorig_d  = aorig_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !cancel_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d = op_i[1];
                            acc_d    = {{WIDTH{1'b0}}, (op_i[1] ? abs_a : abs_b)};
                            opnd_d   = op_i[1] ? abs_b : abs_a;
                            neg_d    = op_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            rneg_d   = op_signed & op_i[1] & a_i[WIDTH-1];
                            dz_d     = op_i[1] & (b_i == '0);
                            aorig_d  = a_i;
                            cnt_d    = '0;
                            state_d  = S_RUN;
                        end
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        if (!is_div_q) begin
                            hi_d = prod[2*WIDTH-1:WIDTH];
                            lo_d = prod[WIDTH-1:0];
                        end else if (dz_q) begin
                            // Zero divisor reports the raw dividend, no sign fix-up.
                            hi_d = aorig_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            aorig_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            aorig_q  <= aorig_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit at WIDTH 32 and 8
module tb_mul_div_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, start32, cancel32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;

    logic        rst8, start8, cancel8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst32), .start_i(start32), .op_i(op32),
        .a_i(a32), .b_i(b32), .cancel_i(cancel32),
        .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32)
    );

    mul_div_unit #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst8), .start_i(start8), .op_i(op8),
        .a_i(a8), .b_i(b8), .cancel_i(cancel8),
        .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic op32_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        int   cyc;
        logic seen;
        @(negedge clk);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        for (int g = 0; g < 100 && !seen; g++) begin
            if (done32) seen = 1'b1;
            else begin
                if (busy32) cyc++;
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_cycles"}, 64'(cyc), 64'd32);
        check({tag, "_busy_at_done"}, 64'(busy32), 64'd0);
        check({tag, "_hi"}, 64'(hi32), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo32), 64'(exp_lo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done32), 64'd0);
    endtask

    initial begin
        int   cyc, dn;
        logic seen;
        rst32 = 1'b1; start32 = 1'b0; cancel32 = 1'b0; op32 = 3'b000; a32 = '0; b32 = '0;
        rst8  = 1'b1; start8  = 1'b0; cancel8  = 1'b0; op8  = 3'b000; a8  = '0; b8  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_hi", 64'(hi32), 64'd0);
        check("rst_lo", 64'(lo32), 64'd0);
        rst32 = 1'b0;
        rst8  = 1'b0;

        op32_run("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        op32_run("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        op32_run("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
        op32_run("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        op32_run("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        op32_run("divu_zero", 3'b011, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF);

        @(negedge clk);
        start32 = 1'b1; op32 = 3'b100; a32 = 32'hAAAA5555;
        @(negedge clk);
        start32 = 1'b0;
        check("mthi_hi", 64'(hi32), 64'hAAAA5555);
        check("mthi_busy", 64'(busy32), 64'd0);
        start32 = 1'b1; op32 = 3'b101; a32 = 32'h12345678;
        @(negedge clk);
        start32 = 1'b0;
        check("mtlo_lo", 64'(lo32), 64'h12345678);
        check("mtlo_busy", 64'(busy32), 64'd0);

        start32 = 1'b1; op32 = 3'b110; a32 = 32'hDEADBEEF;
        @(negedge clk);
        start32 = 1'b0;
        check("op110_hi", 64'(hi32), 64'hAAAA5555);
        check("op110_lo", 64'(lo32), 64'h12345678);
        check("op110_busy", 64'(busy32), 64'd0);

        start32 = 1'b1; cancel32 = 1'b1; op32 = 3'b000; a32 = 32'd5; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0; cancel32 = 1'b0;
        check("idle_cancel_busy", 64'(busy32), 64'd0);

        start32 = 1'b1; op32 = 3'b000; a32 = 32'd5; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        check("cancel_run_busy", 64'(busy32), 64'd1);
        repeat (9) @(negedge clk);
        cancel32 = 1'b1;
        @(negedge clk);
        cancel32 = 1'b0;
        check("cancel_busy", 64'(busy32), 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) dn++;
        end
        check("cancel_no_done", 64'(dn), 64'd0);
        check("cancel_hi", 64'(hi32), 64'hAAAA5555);
        check("cancel_lo", 64'(lo32), 64'h12345678);

        @(negedge clk);
        start8 = 1'b1; op8 = 3'b000; a8 = 8'h80; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        op8    = 3'b011;
        cyc    = 0;
        seen   = 1'b0;
        for (int g = 0; g < 100 && !seen; g++) begin
            if (done8) seen = 1'b1;
            else begin
                if (busy8) cyc++;
                start8 = (g == 2);
                @(negedge clk);
            end
        end
        start8 = 1'b0;
        check("w8_done_seen", 64'(seen), 64'd1);
        check("w8_busy_cycles", 64'(cyc), 64'd8);
        check("w8_hi", 64'(hi8), 64'h00);
        check("w8_lo", 64'(lo8), 64'h80);
        @(negedge clk);
        check("w8_no_queue_busy", 64'(busy8), 64'd0);
        check("w8_done_pulse", 64'(done8), 64'd0);

        start8 = 1'b1; op8 = 3'b000; a8 = 8'd3; b8 = 8'd5;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("w8_pre_rst_busy", 64'(busy8), 64'd1);
        rst8 = 1'b1;
        #1;
        check("w8_rst_busy", 64'(busy8), 64'd0);
        check("w8_rst_hi", 64'(hi8), 64'd0);
        check("w8_rst_lo", 64'(lo8), 64'd0);
        @(negedge clk);
        rst8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
